// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl -- central sequencer for the five-stage MIPS pipeline.
//
// Generates the enables for the PC register and the IF/ID, ID/EX, EX/MEM and
// MEM/WB pipeline registers, plus bubble selects for IF/ID and ID/EX.
// Handles load-use stalls, taken-branch flushes, multi-cycle mul/div freezes
// and a syscall halt/resume. Keeps a saturating stall-cycle counter.
//
// Ports:
//   Clock        rising-edge clock
//   Resetn       synchronous reset, active low
//   LoadUse      ID-stage load-use hazard
//   BranchTaken  EX stage resolved a taken branch/jump
//   MulDivStart  one-cycle pulse: mul/div in EX
//   MulDivIsDiv  qualifies MulDivStart (1 = divide)
//   Halt         syscall halt request (level)
//   Resume       leave the halted state
//   PC_Enable, IFID_Enable, IDEX_Enable, EXMEM_Enable, MEMWB_Enable
//                register enables
//   IFID_Flush, IDEX_Flush  bubble selects
//   MulDivBusy   registered state is MULDIV
//   Halted       registered state is HALTED
//   StallCount   cycles with PC_Enable=0 since reset (saturating)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 LoadUse,
  input  logic                 BranchTaken,
  input  logic                 MulDivStart,
  input  logic                 MulDivIsDiv,
  input  logic                 Halt,
  input  logic                 Resume,
  output logic                 PC_Enable,
  output logic                 IFID_Enable,
  output logic                 IDEX_Enable,
  output logic                 EXMEM_Enable,
  output logic                 MEMWB_Enable,
  output logic                 IFID_Flush,
  output logic                 IDEX_Flush,
  output logic                 MulDivBusy,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] StallCount
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_MULDIV = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // The start cycle is itself a freeze cycle, so the counter is loaded with
  // N-1 and the release happens on the cycle it reads zero.
  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= S_RUN;
      cnt_q       <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (Halt) begin
          state_d = S_HALTED;
        end else if (MulDivStart) begin
          state_d = S_MULDIV;
          cnt_d   = MulDivIsDiv ? DIV_LOAD : MUL_LOAD;
        end
      end
      S_MULDIV: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HALTED: begin
        if (Resume) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    PC_Enable    = 1'b1;
    IFID_Enable  = 1'b1;
    IDEX_Enable  = 1'b1;
    EXMEM_Enable = 1'b1;
    MEMWB_Enable = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (Halt) begin
          PC_Enable    = 1'b0;
          IFID_Enable  = 1'b0;
          IDEX_Enable  = 1'b0;
          EXMEM_Enable = 1'b0;
          MEMWB_Enable = 1'b0;
        end else if (MulDivStart) begin
          // Let the instruction ahead of the mul/div retire through MEM/WB.
          PC_Enable    = 1'b0;
          IFID_Enable  = 1'b0;
          IDEX_Enable  = 1'b0;
          EXMEM_Enable = 1'b0;
        end else if (BranchTaken) begin
          // Squash both wrong-path instructions; any load-use stall on them
          // is moot.
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end else if (LoadUse) begin
          PC_Enable   = 1'b0;
          IFID_Enable = 1'b0;
          IDEX_Flush  = 1'b1;
        end
      end
      S_MULDIV: begin
        if (cnt_q != 8'd0) begin
          PC_Enable    = 1'b0;
          IFID_Enable  = 1'b0;
          IDEX_Enable  = 1'b0;
          EXMEM_Enable = 1'b0;
        end
      end
      S_HALTED: begin
        PC_Enable    = 1'b0;
        IFID_Enable  = 1'b0;
        IDEX_Enable  = 1'b0;
        EXMEM_Enable = 1'b0;
        MEMWB_Enable = 1'b0;
      end
      default: ;
    endcase

    // During reset, advance every stage with bubbles but hold the PC.
    if (!Resetn) begin
      PC_Enable    = 1'b0;
      IFID_Enable  = 1'b1;
      IDEX_Enable  = 1'b1;
      EXMEM_Enable = 1'b1;
      MEMWB_Enable = 1'b1;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
    end
  end

  // Saturating stall counter; reset cycles are excluded by the register reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Enable && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  assign MulDivBusy = (state_q == S_MULDIV);
  assign Halted     = (state_q == S_HALTED);
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl -- directed self-checking bench for pipeline_ctrl.
// Two instances share all inputs: one with default parameters, one with a
// 4-bit stall counter for the saturation case.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic Clock = 1'b0;
  logic Resetn, LoadUse, BranchTaken, MulDivStart, MulDivIsDiv, Halt, Resume;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl;
  logic        busy, halted;
  logic [15:0] stall;

  logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_fl4, idex_fl4;
  logic        busy4, halted4;
  logic [3:0]  stall4;

  always #5 Clock = ~Clock;

  pipeline_ctrl dut (
    .Clock(Clock), .Resetn(Resetn), .LoadUse(LoadUse), .BranchTaken(BranchTaken),
    .MulDivStart(MulDivStart), .MulDivIsDiv(MulDivIsDiv), .Halt(Halt), .Resume(Resume),
    .PC_Enable(pc_en), .IFID_Enable(ifid_en), .IDEX_Enable(idex_en),
    .EXMEM_Enable(exmem_en), .MEMWB_Enable(memwb_en),
    .IFID_Flush(ifid_fl), .IDEX_Flush(idex_fl),
    .MulDivBusy(busy), .Halted(halted), .StallCount(stall)
  );

  pipeline_ctrl #(.CNT_WIDTH(4)) dut4 (
    .Clock(Clock), .Resetn(Resetn), .LoadUse(LoadUse), .BranchTaken(BranchTaken),
    .MulDivStart(MulDivStart), .MulDivIsDiv(MulDivIsDiv), .Halt(Halt), .Resume(Resume),
    .PC_Enable(pc_en4), .IFID_Enable(ifid_en4), .IDEX_Enable(idex_en4),
    .EXMEM_Enable(exmem_en4), .MEMWB_Enable(memwb_en4),
    .IFID_Flush(ifid_fl4), .IDEX_Flush(idex_fl4),
    .MulDivBusy(busy4), .Halted(halted4), .StallCount(stall4)
  );

  // ctl bit order: {PC, IFID, IDEX, EXMEM, MEMWB, IFID_Flush, IDEX_Flush}
  localparam logic [6:0] RUNC = 7'b11111_00;
  localparam logic [6:0] RSTC = 7'b01111_11;
  localparam logic [6:0] HLTC = 7'b00000_00;
  localparam logic [6:0] FRZC = 7'b00001_00;
  localparam logic [6:0] LUC  = 7'b00111_01;
  localparam logic [6:0] BRC  = 7'b11111_11;

  typedef struct packed {
    logic [6:0]  ctl;
    logic        busy;
    logic        halted;
    logic [15:0] stall;
    logic [3:0]  stall4;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_stall = 16'd0;
  logic [3:0]  exp_stall4 = 4'd0;

  // One clock cycle: drive inputs, queue the expected outputs for this cycle,
  // compare at the falling edge, then account for the coming rising edge.
  task automatic step(input logic rst_n, input logic lu, input logic br,
                      input logic mds, input logic isdiv, input logic hlt,
                      input logic res, input logic [6:0] ctl,
                      input logic e_busy, input logic e_halted, input string tag);
    exp_t e, got;
    Resetn = rst_n; LoadUse = lu; BranchTaken = br; MulDivStart = mds;
    MulDivIsDiv = isdiv; Halt = hlt; Resume = res;
    e.ctl = ctl; e.busy = e_busy; e.halted = e_halted;
    e.stall = exp_stall; e.stall4 = exp_stall4;
    sb_q.push_back(e);
    @(negedge Clock);
    e = sb_q.pop_front();
    got.ctl    = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl};
    got.busy   = busy;
    got.halted = halted;
    got.stall  = stall;
    got.stall4 = stall4;
    checks++;
    assert ({got.ctl, got.busy, got.halted, got.stall} === {e.ctl, e.busy, e.halted, e.stall})
    else begin
      errors++;
      $error("FAIL %s: ctl/busy/halted/stall got %b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, got.ctl, got.busy, got.halted, got.stall,
             e.ctl, e.busy, e.halted, e.stall);
    end
    checks++;
    assert (got.stall4 === e.stall4)
    else begin
      errors++;
      $error("FAIL %s_sat4: StallCount got %0d expected %0d", tag, got.stall4, e.stall4);
    end
    $display("step %-10s rst_n=%b lu=%b br=%b mds=%b div=%b halt=%b res=%b ctl=%b busy=%b halted=%b stall=%0d stall4=%0d",
             tag, rst_n, lu, br, mds, isdiv, hlt, res, got.ctl, got.busy, got.halted,
             got.stall, got.stall4);
    if (!rst_n) begin
      exp_stall  = 16'd0;
      exp_stall4 = 4'd0;
    end else if (!ctl[6]) begin
      exp_stall = exp_stall + 16'd1;
      if (exp_stall4 != 4'hF) exp_stall4 = exp_stall4 + 4'd1;
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Resetn = 1'b0; LoadUse = 1'b0; BranchTaken = 1'b0; MulDivStart = 1'b0;
    MulDivIsDiv = 1'b0; Halt = 1'b0; Resume = 1'b0;
    @(posedge Clock);
    #1;

    // Reset: bubbles through the stages, PC held
    step(0,0,0,0,0,0,0, RSTC, 0,0, "reset1");
    step(0,0,0,0,0,0,0, RSTC, 0,0, "reset2");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "idle");

    // Load-use, then load-use masked by a taken branch
    step(1,1,0,0,0,0,0, LUC,  0,0, "loaduse");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "idle");
    step(1,1,1,0,0,0,0, BRC,  0,0, "lu_branch");
    step(1,0,1,0,0,0,0, BRC,  0,0, "branch");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "idle");

    // Multiply: 4 freeze cycles, hazards ignored at t+2
    step(1,0,0,1,0,0,0, FRZC, 0,0, "mul_t0");
    step(1,0,0,0,0,0,0, FRZC, 1,0, "mul_t1");
    step(1,1,1,0,0,0,0, FRZC, 1,0, "mul_t2");
    step(1,0,0,0,0,0,0, FRZC, 1,0, "mul_t3");
    step(1,0,0,0,0,0,0, RUNC, 1,0, "mul_rel");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "idle");

    // Divide: 32 freeze cycles
    step(1,0,0,1,1,0,0, FRZC, 0,0, "div_t0");
    for (int i = 1; i < 32; i++) step(1,0,0,0,0,0,0, FRZC, 1,0, "div_frz");
    step(1,0,0,0,0,0,0, RUNC, 1,0, "div_rel");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "idle");

    // Divide aborted by reset at freeze cycle 10
    step(1,0,0,1,1,0,0, FRZC, 0,0, "div2_t0");
    for (int i = 2; i < 10; i++) step(1,0,0,0,0,0,0, FRZC, 1,0, "div2_frz");
    step(0,0,0,0,0,0,0, RSTC, 1,0, "div2_rst");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "post_rst");

    // Halt held, then Halt+Resume together
    step(1,0,0,0,0,1,0, HLTC, 0,0, "halt_t0");
    step(1,0,0,0,0,1,0, HLTC, 0,1, "halt_t1");
    step(1,0,0,0,0,1,0, HLTC, 0,1, "halt_t2");
    step(1,0,0,0,0,1,1, HLTC, 0,1, "halt_res");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "resumed");
    step(1,0,0,0,0,0,1, RUNC, 0,0, "res_run");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "idle");

    // Halt wins over a simultaneous mul/div start
    step(1,0,0,1,0,1,0, HLTC, 0,0, "halt_mds");
    step(1,0,0,0,0,0,1, HLTC, 0,1, "halt_res2");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "idle");

    // Halt during multiply takes effect only after the release cycle
    step(1,0,0,1,0,0,0, FRZC, 0,0, "mh_t0");
    step(1,0,0,0,0,1,1, FRZC, 1,0, "mh_t1");
    step(1,0,0,0,0,1,0, FRZC, 1,0, "mh_t2");
    step(1,0,0,0,0,1,0, FRZC, 1,0, "mh_t3");
    step(1,0,0,0,0,1,0, RUNC, 1,0, "mh_rel");
    step(1,0,0,0,0,1,0, HLTC, 0,0, "mh_halt");
    step(1,0,0,0,0,1,0, HLTC, 0,1, "mh_halted");
    step(1,0,0,0,0,0,1, HLTC, 0,1, "mh_res");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "idle");

    // Saturation: fresh reset, 20 load-use cycles
    step(0,0,0,0,0,0,0, RSTC, 0,0, "sat_rst");
    for (int i = 0; i < 20; i++) step(1,1,0,0,0,0,0, LUC, 0,0, "sat_lu");
    step(1,0,0,0,0,0,0, RUNC, 0,0, "sat_end");

    checks++;
    assert (stall4 === 4'hF)
    else begin
      errors++;
      $error("FAIL sat_final: StallCount got %0d expected 15", stall4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the five-stage MIPS pipeline. It generates the Enable inputs for the PC register and the four pipeline Register instances (IF/ID, ID/EX, EX/MEM, MEM/WB). It also generates bubble/flush selects for IF/ID and ID/EX. It handles load-use stalls, taken-branch flushes, multi-cycle mul/div freezes and a syscall halt/resume, and keeps a stall-cycle counter for performance debug.

Parameters:
MUL_CYCLES, 4, total freeze cycles for a multiply; legal range 2..255
DIV_CYCLES, 32, total freeze cycles for a divide; legal range 2..255
CNT_WIDTH, 16, width of the stall-cycle counter

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  synchronous reset, active low
LoadUse  input  1  ID-stage hazard unit reports a load-use dependency
BranchTaken  input  1  EX stage resolves a taken branch or jump
MulDivStart  input  1  mul/div instruction is in EX this cycle (one-cycle pulse)
MulDivIsDiv  input  1  qualifies MulDivStart: 1 = divide, 0 = multiply
Halt  input  1  syscall halt request; level, held by the source until Halted=1
Resume  input  1  leave the halted state
PC_Enable  output  1  enable for the PC register
IFID_Enable, IDEX_Enable, EXMEM_Enable, MEMWB_Enable  output  1 each  pipeline register enables
IFID_Flush, IDEX_Flush  output  1 each  select NOP/bubble data into the register
MulDivBusy  output  1  state == MULDIV
Halted  output  1  state == HALTED
StallCount  output  CNT_WIDTH  cycles with PC_Enable=0 since reset

Behaviour:
- Sync active-low reset: one cycle Resetn=0 at a posedge gives state=RUN, mul/div counter=0, StallCount=0.
- While Resetn=0 (combinational override): PC_Enable=0; IFID/IDEX/EXMEM/MEMWB_Enable=1; IFID_Flush=IDEX_Flush=1, so bubbles fill the pipeline. StallCount does not count.
- Reset mid-MULDIV or mid-HALTED aborts immediately to RUN.
- Enables and flushes are combinational from state, count and inputs. State, count and StallCount are registered.
- States: RUN, MULDIV, HALTED. The 8-bit down-counter cnt is used only in MULDIV.
- RUN input priority is Halt > MulDivStart > BranchTaken > LoadUse:
  - Halt: all enables 0, flushes 0; next state HALTED.
  - MulDivStart: PC/IFID/IDEX/EXMEM enables 0, MEMWB_Enable 1, flushes 0. Load cnt = (IsDiv ? DIV_CYCLES : MUL_CYCLES) - 1; next state MULDIV.
  - BranchTaken (LoadUse ignored): all enables 1, IFID_Flush=1, IDEX_Flush=1.
  - LoadUse only: PC_Enable=0, IFID_Enable=0, IDEX_Flush=1, other enables 1.
  - None asserted: all enables 1, flushes 0.
- MULDIV:
  - cnt != 0: same freeze as the start cycle; cnt decrements.
  - cnt == 0: release cycle with all enables 1, flushes 0; next state RUN.
  - LoadUse, BranchTaken, Halt and MulDivStart are ignored in this state. Halt is honoured once back in RUN because it is a held level.
  - Total freeze is exactly N cycles, the start cycle included.
- HALTED: all enables 0, flushes 0. Resume gives next state RUN; Resume wins over a simultaneous Halt. Resume in RUN or MULDIV is ignored.
- StallCount increments on every non-reset cycle where PC_Enable=0, and saturates at all-ones (no wrap).
- MulDivBusy and Halted decode the registered state. Their reset value is 0.

Test Plan:
- Reset: hold Resetn=0 for 2 cycles with all inputs 0 -> PC_Enable=0, stage enables=1, both flushes=1. After release: all enables 1, flushes 0, StallCount=0, MulDivBusy=0, Halted=0.
- Load-use: pulse LoadUse for 1 cycle -> that cycle PC_Enable=0, IFID_Enable=0, IDEX_Flush=1; StallCount becomes 1. LoadUse with BranchTaken in the same cycle -> both flushes 1, PC_Enable=1, StallCount unchanged.
- Multiply: MulDivStart=1, MulDivIsDiv=0 at cycle t -> PC_Enable=0 at t..t+3, MEMWB_Enable=1 throughout, all enables 1 at t+4, MulDivBusy=1 at t+1..t+4, StallCount=4. LoadUse and BranchTaken asserted at t+2 have no effect.
- Divide: DIV_CYCLES=32 -> exactly 32 freeze cycles, StallCount=32. Reset asserted at freeze cycle 10 -> RUN next cycle, MulDivBusy=0.
- Halt: hold Halt from cycle t -> enables 0 at t, Halted=1 from t+1. Then Halt=Resume=1 together -> Halted=0 on the next cycle. Halt asserted during MULDIV -> HALTED entered only after the release cycle.
- Saturation: CNT_WIDTH=4, hold LoadUse for 20 cycles -> StallCount stops at 15.
